// File: rtl/vector_alu_sched.sv
// ---------------------------------------------------------------------------
// vector_alu_sched
//   Arbitrates two requesters (A and B) onto a shared, fixed-latency vector
//   ALU pipeline. A small tracker follows each issued op down the pipeline so
//   that the result leaving the ALU can be labelled with its origin, tag and
//   opcode. Backpressure from the result consumer stalls the whole pipeline.
//
// Parameters
//   LAT   - ALU pipeline depth in cycles (1..4)
//   TAGW  - width of requester transaction tag
//
// Ports
//   clk, rst_n            - clock, asynchronous active-low reset
//   a_valid/b_valid       - requester has an op to issue
//   a_ready/b_ready       - op accepted this cycle (combinational)
//   a_op/b_op, a_tag/b_tag- opcode and tag of each requester
//   flush                 - discard every in-flight op at the next edge
//   alu_en                - ALU pipeline advance enable
//   alu_op, alu_sel_b     - opcode and operand select driven to the ALU
//   res_valid/res_ready   - result handshake at the ALU output
//   res_src/res_tag/res_op- origin (0 = A), tag and opcode of the result
//   inflight              - number of valid ops held in the tracker
// ---------------------------------------------------------------------------
module vector_alu_sched #(
    parameter int LAT  = 2,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    input  logic            b_valid,
    output logic            a_ready,
    output logic            b_ready,
    input  logic [4:0]      a_op,
    input  logic [4:0]      b_op,
    input  logic [TAGW-1:0] a_tag,
    input  logic [TAGW-1:0] b_tag,
    input  logic            flush,
    output logic            alu_en,
    output logic [4:0]      alu_op,
    output logic            alu_sel_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_src,
    output logic [TAGW-1:0] res_tag,
    output logic [4:0]      res_op,
    output logic [2:0]      inflight
);

    logic [LAT-1:0]  stage_valid;
    logic [LAT-1:0]  stage_src;
    logic [TAGW-1:0] stage_tag [LAT];
    logic [4:0]      stage_op  [LAT];

    logic [LAT-1:0]  valid_next;
    logic [2:0]      inflight_next;

    logic            rr_b;
    logic            sel_b_q;
    logic            grant_ok;
    logic            grant_a;
    logic            grant_b;
    logic            grant;

    // The pipeline only stalls when a finished result is waiting on a
    // consumer that is not taking it.
    assign alu_en = ~(stage_valid[LAT-1] & ~res_ready);

    // rst_n gates the grant so that no ready is ever seen during reset.
    assign grant_ok = alu_en & ~flush & rst_n;
    assign grant_a  = grant_ok & a_valid & (~b_valid | ~rr_b);
    assign grant_b  = grant_ok & b_valid & (~a_valid |  rr_b);
    assign grant    = grant_a | grant_b;

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign alu_op    = grant_a ? a_op : (grant_b ? b_op : 5'd0);
    assign alu_sel_b = grant ? grant_b : sel_b_q;

    assign res_valid = stage_valid[LAT-1];
    assign res_src   = stage_src[LAT-1];
    assign res_tag   = stage_tag[LAT-1];
    assign res_op    = stage_op[LAT-1];

    // Next tracker occupancy; flush wins over both the shift and the grant.
    always_comb begin
        valid_next    = stage_valid;
        inflight_next = 3'd0;
        if (flush) begin
            valid_next = '0;
        end else if (alu_en) begin
            valid_next[0] = grant;
            for (int i = 1; i < LAT; i++) begin
                valid_next[i] = stage_valid[i-1];
            end
        end
        for (int i = 0; i < LAT; i++) begin
            inflight_next = inflight_next + {2'b00, valid_next[i]};
        end
    end

    // Control state: valid bits, occupancy count, arbitration pointer and
    // the remembered operand select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            inflight    <= 3'd0;
            rr_b        <= 1'b0;
            sel_b_q     <= 1'b0;
        end else begin
            stage_valid <= valid_next;
            inflight    <= inflight_next;
            if (grant) begin
                rr_b    <= grant_a;
                sel_b_q <= grant_b;
            end
        end
    end

    // Payload fields need no reset; they are only observed through a set
    // valid bit. They move in lockstep with the valids on every advance.
    always_ff @(posedge clk) begin
        if (alu_en && !flush) begin
            stage_src[0] <= grant_b;
            stage_tag[0] <= grant_b ? b_tag : a_tag;
            stage_op[0]  <= alu_op;
            for (int i = 1; i < LAT; i++) begin
                stage_src[i] <= stage_src[i-1];
                stage_tag[i] <= stage_tag[i-1];
                stage_op[i]  <= stage_op[i-1];
            end
        end
    end

endmodule

// File: tb/tb_vector_alu_sched.sv
// ---------------------------------------------------------------------------
// tb_vector_alu_sched
//   Directed self-checking bench for vector_alu_sched with LAT=2, TAGW=4.
//   Inputs are changed 1 time unit after each rising edge and outputs are
//   sampled 1 time unit later, well away from the next rising edge.
// ---------------------------------------------------------------------------
module tb_vector_alu_sched;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic       b_valid;
    logic       a_ready;
    logic       b_ready;
    logic [4:0] a_op;
    logic [4:0] b_op;
    logic [3:0] a_tag;
    logic [3:0] b_tag;
    logic       flush;
    logic       alu_en;
    logic [4:0] alu_op;
    logic       alu_sel_b;
    logic       res_valid;
    logic       res_ready;
    logic       res_src;
    logic [3:0] res_tag;
    logic [4:0] res_op;
    logic [2:0] inflight;

    int checks;
    int failures;

    vector_alu_sched #(.LAT(2), .TAGW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .a_ready   (a_ready),
        .b_ready   (b_ready),
        .a_op      (a_op),
        .b_op      (b_op),
        .a_tag     (a_tag),
        .b_tag     (b_tag),
        .flush     (flush),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_sel_b (alu_sel_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_src   (res_src),
        .res_tag   (res_tag),
        .res_op    (res_op),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time guard so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all requester-side inputs for the current cycle, then let the
    // combinational outputs settle.
    task automatic applyStimulus(input logic av, input logic [3:0] at, input logic [4:0] ao,
                                 input logic bv, input logic [3:0] bt, input logic [4:0] bo,
                                 input logic rr, input logic fl);
        a_valid   = av;
        a_tag     = at;
        a_op      = ao;
        b_valid   = bv;
        b_tag     = bt;
        b_op      = bo;
        res_ready = rr;
        flush     = fl;
        #1;
    endtask

    // Common per-cycle expectations for handshakes and the presented result.
    task automatic expectCycle(input string name, input logic ea, input logic eb,
                               input logic een, input logic erv, input logic [3:0] etag);
        checkOutput({name, ".a_ready"},   32'(a_ready),   32'(ea));
        checkOutput({name, ".b_ready"},   32'(b_ready),   32'(eb));
        checkOutput({name, ".alu_en"},    32'(alu_en),    32'(een));
        checkOutput({name, ".res_valid"}, 32'(res_valid), 32'(erv));
        if (erv) begin
            checkOutput({name, ".res_tag"}, 32'(res_tag), 32'(etag));
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_op      = 5'd0;
        b_op      = 5'd0;
        a_tag     = 4'd0;
        b_tag     = 4'd0;
        flush     = 1'b0;
        res_ready = 1'b1;

        // Reset values, with A asking for service while reset is held.
        tick();
        applyStimulus(1'b1, 4'd5, 5'h03, 1'b1, 4'd2, 5'h02, 1'b1, 1'b0);
        expectCycle("rst", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("rst.inflight",  32'(inflight),  32'd0);
        checkOutput("rst.alu_sel_b", 32'(alu_sel_b), 32'd0);
        checkOutput("rst.alu_op",    32'(alu_op),    32'd0);
        doReset();

        // Single op from A: granted immediately, result two cycles later.
        applyStimulus(1'b1, 4'd5, 5'h03, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        expectCycle("a_only.c0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("a_only.c0.alu_op",    32'(alu_op),    32'h03);
        checkOutput("a_only.c0.alu_sel_b", 32'(alu_sel_b), 32'd0);
        tick();
        applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        expectCycle("a_only.c1", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("a_only.c1.inflight", 32'(inflight), 32'd1);
        checkOutput("a_only.c1.alu_op",   32'(alu_op),   32'd0);
        tick();
        expectCycle("a_only.c2", 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
        checkOutput("a_only.c2.res_src", 32'(res_src), 32'd0);
        checkOutput("a_only.c2.res_op",  32'(res_op),  32'h03);
        tick();
        expectCycle("a_only.c3", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("a_only.c3.inflight", 32'(inflight), 32'd0);

        // Both requesters continuously: strict A,B,A,B after a fresh reset,
        // results back in grant order one per cycle.
        doReset();
        for (int k = 0; k < 7; k++) begin
            logic ea;
            logic eb;
            logic erv;
            logic [3:0] etag;
            ea   = (k < 4) && (k % 2 == 0);
            eb   = (k < 4) && (k % 2 == 1);
            erv  = (k >= 2) && (k <= 5);
            etag = (k % 2 == 0) ? 4'd1 : 4'd2;
            applyStimulus(k < 4, 4'd1, 5'h01, k < 4, 4'd2, 5'h02, 1'b1, 1'b0);
            expectCycle($sformatf("rr.c%0d", k), ea, eb, 1'b1, erv, etag);
            if (erv) begin
                checkOutput($sformatf("rr.c%0d.res_src", k), 32'(res_src), 32'(k % 2));
            end
            if (ea || eb) begin
                checkOutput($sformatf("rr.c%0d.alu_sel_b", k), 32'(alu_sel_b), 32'(eb));
                checkOutput($sformatf("rr.c%0d.alu_op", k), 32'(alu_op), eb ? 32'h02 : 32'h01);
            end
            tick();
        end
        // Last grant was B; with nothing granted the select must stay on B.
        checkOutput("rr.hold.alu_sel_b", 32'(alu_sel_b), 32'd1);
        checkOutput("rr.hold.alu_op",    32'(alu_op),    32'd0);
        checkOutput("rr.end.inflight",   32'(inflight),  32'd0);

        // Backpressure with a full pipeline for three cycles.
        applyStimulus(1'b1, 4'd3, 5'h0a, 1'b1, 4'd4, 5'h0b, 1'b1, 1'b0);
        expectCycle("bp.c0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 4'd3, 5'h0a, 1'b1, 4'd4, 5'h0b, 1'b1, 1'b0);
        expectCycle("bp.c1", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        for (int k = 2; k < 5; k++) begin
            applyStimulus(1'b1, 4'd3, 5'h0a, 1'b1, 4'd4, 5'h0b, 1'b0, 1'b0);
            expectCycle($sformatf("bp.c%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
            checkOutput($sformatf("bp.c%0d.res_op", k),   32'(res_op),   32'h0a);
            checkOutput($sformatf("bp.c%0d.inflight", k), 32'(inflight), 32'd2);
            tick();
        end
        applyStimulus(1'b1, 4'd3, 5'h0a, 1'b1, 4'd4, 5'h0b, 1'b1, 1'b0);
        expectCycle("bp.c5", 1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
        tick();
        applyStimulus(1'b1, 4'd3, 5'h0a, 1'b1, 4'd4, 5'h0b, 1'b1, 1'b0);
        expectCycle("bp.c6", 1'b0, 1'b1, 1'b1, 1'b1, 4'd4);
        checkOutput("bp.c6.res_src", 32'(res_src), 32'd1);
        tick();
        applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        expectCycle("bp.c7", 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        tick();
        expectCycle("bp.c8", 1'b0, 1'b0, 1'b1, 1'b1, 4'd4);
        tick();
        expectCycle("bp.c9", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Flush with two ops in flight while A is still requesting.
        applyStimulus(1'b1, 4'd6, 5'h04, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        expectCycle("fl.c0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 4'd7, 5'h05, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        expectCycle("fl.c1", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 4'd8, 5'h06, 1'b0, 4'd0, 5'd0, 1'b1, 1'b1);
        expectCycle("fl.c2", 1'b0, 1'b0, 1'b1, 1'b1, 4'd6);
        checkOutput("fl.c2.inflight", 32'(inflight), 32'd2);
        tick();
        applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        expectCycle("fl.c3", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("fl.c3.inflight", 32'(inflight), 32'd0);
        tick();
        expectCycle("fl.c4", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Reset in the middle of traffic drops both ops.
        applyStimulus(1'b1, 4'd8, 5'h07, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd9, 5'h08, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("mr.pre.inflight", 32'(inflight), 32'd2);
        rst_n = 1'b0;
        #1;
        expectCycle("mr.in_reset", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("mr.in_reset.inflight", 32'(inflight), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            expectCycle($sformatf("mr.post%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            tick();
        end
        applyStimulus(1'b1, 4'd10, 5'h1f, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        expectCycle("mr.new.c0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0);
        expectCycle("mr.new.c1", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        expectCycle("mr.new.c2", 1'b0, 1'b0, 1'b1, 1'b1, 4'd10);
        checkOutput("mr.new.c2.res_op", 32'(res_op), 32'h1f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_alu_sched.md
VECTOR_ALU_SCHED -- requirements
Module: vector_alu_sched

Interface
REQ-001 Parameter: LAT, 2, vector ALU pipeline depth in cycles (legal range 1..4).
REQ-002 Parameter: TAGW, 4, width of requester transaction tag.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, ports named clk and rst_n.
REQ-004 Port: clk  input  1  clock, all state updates on posedge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: a_valid / b_valid  input  1 each  requester A / B has an op to issue.
REQ-007 Port: a_ready / b_ready  output  1 each  op of A / B accepted this cycle.
REQ-008 Port: a_op / b_op  input  5 each  ALU opcode from A / B.
REQ-009 Port: a_tag / b_tag  input  TAGW each  transaction tag from A / B.
REQ-010 Port: flush  input  1  synchronous discard of all in-flight ops.
REQ-011 Port: alu_en  output  1  vector ALU pipeline advance enable.
REQ-012 Port: alu_op  output  5  opcode driven to ALU op input.
REQ-013 Port: alu_sel_b  output  1  operand mux select, 0 = A operands, 1 = B operands.
REQ-014 Port: res_valid  output  1  ALU output (vout/rout) holds a valid result.
REQ-015 Port: res_ready  input  1  consumer accepts the result this cycle.
REQ-016 Port: res_src / res_tag / res_op  output  1 / TAGW / 5  origin requester (0 = A), tag and opcode of the presented result.
REQ-017 Port: inflight  output  3  count of valid ops in the pipeline tracker.

Function
REQ-018 The block SHALL keep a tracker of LAT stages, each holding {valid, src, tag, op}; stage 0 is written at grant, stage LAT-1 aligns with ALU output.
REQ-019 alu_en SHALL equal NOT(stage[LAT-1].valid AND NOT res_ready), combinationally.
REQ-020 The tracker SHALL shift one stage on each clock where alu_en=1 and SHALL hold all stages when alu_en=0.
REQ-021 A grant SHALL occur only when alu_en=1 and flush=0; at most one requester is granted per cycle.
REQ-022 With one requester valid, that requester SHALL be granted; with both valid, the one indicated by the round-robin pointer SHALL be granted.
REQ-023 The round-robin pointer SHALL point to the requester not granted after each grant and SHALL hold when no grant occurs.
REQ-024 a_ready / b_ready SHALL be combinational, asserted only in the grant cycle for the granted side.
REQ-025 alu_op and alu_sel_b SHALL reflect the granted requester in the grant cycle; with no grant, alu_sel_b holds its last value and alu_op = 0.
REQ-026 Stage 0 SHALL load valid=0 on any advancing cycle without a grant (bubble).
REQ-027 res_valid, res_src, res_tag and res_op SHALL be driven from stage[LAT-1]; the result SHALL appear exactly LAT advancing cycles after grant.
REQ-028 While res_valid=1 and res_ready=0, res_* outputs SHALL remain stable and no grant SHALL occur.
REQ-029 flush=1 SHALL clear every stage valid at the next edge; flush takes priority over grant and shift in the same cycle.
REQ-030 inflight SHALL equal the number of set stage valid bits, registered alongside the tracker.
REQ-031 A result SHALL retire and a new op SHALL be granted in the same cycle when res_ready=1, giving full throughput of one op per cycle.

Reset
REQ-032 On rst_n=0 all stage valids, inflight and alu_sel_b SHALL clear to 0, and the pointer SHALL favour A.
REQ-033 During reset a_ready, b_ready and res_valid SHALL be 0 and alu_en SHALL be 1.
REQ-034 Reset asserted mid-operation SHALL drop all in-flight ops with no result presented after release.

Verification
REQ-035 A only: a_valid=1, op=0x03, tag=5, res_ready=1 -> a_ready in cycle 0; res_valid=1, res_src=0, res_tag=5, res_op=0x03 after LAT=2 cycles.
REQ-036 Both valid continuously with tags A=1, B=2 -> grants alternate A,B,A,B starting with A after reset; results return in the same order, one per cycle.
REQ-037 Backpressure: res_ready=0 for 3 cycles with the pipeline full -> alu_en=0, no grants, res_* stable; on res_ready=1, the stream resumes with no loss or duplication.
REQ-038 Flush with 2 ops in flight and a_valid=1 in the same cycle -> a_ready=0, inflight=0 and res_valid=0 next cycle.
REQ-039 Reset asserted with inflight=2 -> after release res_valid stays 0 until a new grant completes.
